// File: rtl/idt_clock_sequencer.sv
// Reprogramming scheduler for the IDT clock synthesizer serial programmer.
// Arbitrates host raw-word writes against video-mode presets, then times shift-out and PLL settle.
//
// state  | meaning
// BOOT   | leaving reset; queues the boot word (MODE0_WORD)
// IDLE   | clock stable; arbitrates pending requests (host first)
// LOAD   | presents the word and strobes the serializer for one cycle
// SHIFT  | waits SHIFT_CYCLES for the serializer to shift and latch
// SETTLE | waits SETTLE_CYCLES for PLL relock, then commits cur_word
module idt_clock_sequencer #(
    parameter logic [23:0] MODE0_WORD    = 24'h311017,
    parameter logic [23:0] MODE1_WORD    = 24'h348BF0,
    parameter logic [23:0] MODE2_WORD    = 24'h311017,
    parameter logic [23:0] MODE3_WORD    = 24'h311017,
    parameter int unsigned SHIFT_CYCLES  = 205,
    parameter int unsigned SETTLE_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_req,
    input  logic [23:0] host_data,
    output logic        host_ack,
    input  logic        mode_req,
    input  logic [1:0]  mode_sel,
    output logic [23:0] cfg_data,
    output logic        cfg_wstr,
    output logic        pix_rst,
    output logic        busy,
    output logic        ready,
    output logic [23:0] cur_word
);

    localparam int unsigned CNT_MAX = (SHIFT_CYCLES > SETTLE_CYCLES) ? SHIFT_CYCLES : SETTLE_CYCLES;
    localparam int          CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SHIFT_LOAD  = CNT_W'(SHIFT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_SETTLE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [23:0]      cfg_data_q, cfg_data_d;
    logic [23:0]      cur_word_q, cur_word_d;
    logic             host_ack_q, host_ack_d;
    logic             host_pend_q, host_pend_d;
    logic [23:0]      host_word_q, host_word_d;
    logic             mode_pend_q, mode_pend_d;
    logic [1:0]       mode_idx_q, mode_idx_d;
    logic             host_clr;
    logic             mode_clr;
    logic [23:0]      preset_word;

    always_comb begin
        case (mode_idx_q)
            2'd0:    preset_word = MODE0_WORD;
            2'd1:    preset_word = MODE1_WORD;
            2'd2:    preset_word = MODE2_WORD;
            default: preset_word = MODE3_WORD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            cnt_q       <= '0;
            cfg_data_q  <= MODE0_WORD;
            cur_word_q  <= MODE0_WORD;
            host_ack_q  <= 1'b0;
            host_pend_q <= 1'b0;
            host_word_q <= '0;
            mode_pend_q <= 1'b0;
            mode_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cfg_data_q  <= cfg_data_d;
            cur_word_q  <= cur_word_d;
            host_ack_q  <= host_ack_d;
            host_pend_q <= host_pend_d;
            host_word_q <= host_word_d;
            mode_pend_q <= mode_pend_d;
            mode_idx_q  <= mode_idx_d;
        end
    end

    // cfg_data_q holds the in-flight word from LOAD until the next LOAD,
    // so it doubles as the word committed to cur_word at end of SETTLE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cfg_data_d = cfg_data_q;
        cur_word_d = cur_word_q;
        host_ack_d = 1'b0;
        host_clr   = 1'b0;
        mode_clr   = 1'b0;

        case (state_q)
            ST_BOOT: begin
                cfg_data_d = MODE0_WORD;
                state_d    = ST_LOAD;
            end
            ST_IDLE: begin
                if (host_pend_q) begin
                    host_clr   = 1'b1;
                    host_ack_d = 1'b1;
                    if (host_word_q != cur_word_q) begin
                        cfg_data_d = host_word_q;
                        state_d    = ST_LOAD;
                    end
                end else if (mode_pend_q) begin
                    mode_clr = 1'b1;
                    if (preset_word != cur_word_q) begin
                        cfg_data_d = preset_word;
                        state_d    = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                cnt_d   = SHIFT_LOAD;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_q == '0) begin
                    cnt_d   = SETTLE_LOAD;
                    state_d = ST_SETTLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    cur_word_d = cfg_data_q;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // A new request wins over the clear from this cycle's arbitration, and
    // the latched value seen by arbitration is the pre-capture one.
    always_comb begin
        host_pend_d = host_req | (host_pend_q & ~host_clr);
        host_word_d = host_req ? host_data : host_word_q;
        mode_pend_d = mode_req | (mode_pend_q & ~mode_clr);
        mode_idx_d  = mode_req ? mode_sel : mode_idx_q;
    end

    assign cfg_data = cfg_data_q;
    assign cfg_wstr = (state_q == ST_LOAD);
    assign host_ack = host_ack_q;
    assign ready    = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign pix_rst  = (state_q != ST_IDLE);
    assign cur_word = cur_word_q;

endmodule

// File: tb/tb_idt_clock_sequencer.sv
// Directed bench for idt_clock_sequencer with a short settle period (8 cycles).
module tb_idt_clock_sequencer;

    logic        clk;
    logic        rst;
    logic        host_req;
    logic [23:0] host_data;
    logic        host_ack;
    logic        mode_req;
    logic [1:0]  mode_sel;
    logic [23:0] cfg_data;
    logic        cfg_wstr;
    logic        pix_rst;
    logic        busy;
    logic        ready;
    logic [23:0] cur_word;

    int checks;
    int failures;

    logic [23:0] wstr_log[$];
    logic        wstr_ack_log[$];
    int          ack_cnt;

    idt_clock_sequencer #(
        .SETTLE_CYCLES(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .host_req (host_req),
        .host_data(host_data),
        .host_ack (host_ack),
        .mode_req (mode_req),
        .mode_sel (mode_sel),
        .cfg_data (cfg_data),
        .cfg_wstr (cfg_wstr),
        .pix_rst  (pix_rst),
        .busy     (busy),
        .ready    (ready),
        .cur_word (cur_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cfg_wstr === 1'b1) begin
            wstr_log.push_back(cfg_data);
            wstr_ack_log.push_back(host_ack);
        end
        if (host_ack === 1'b1) ack_cnt++;
    end

    task automatic clear_logs();
        wstr_log.delete();
        wstr_ack_log.delete();
        ack_cnt = 0;
    endtask

    task automatic pulse_host(input logic [23:0] d);
        @(negedge clk);
        host_req  = 1'b1;
        host_data = d;
        @(negedge clk);
        host_req  = 1'b0;
    endtask

    task automatic pulse_mode(input logic [1:0] s);
        @(negedge clk);
        mode_req = 1'b1;
        mode_sel = s;
        @(negedge clk);
        mode_req = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks += 7;
        if (cfg_data !== 24'h311017) begin failures++; $display("FAIL rst_cfg_data got=%h exp=311017", cfg_data); end
        if (cur_word !== 24'h311017) begin failures++; $display("FAIL rst_cur_word got=%h exp=311017", cur_word); end
        if (cfg_wstr !== 1'b0) begin failures++; $display("FAIL rst_cfg_wstr got=%b exp=0", cfg_wstr); end
        if (host_ack !== 1'b0) begin failures++; $display("FAIL rst_host_ack got=%b exp=0", host_ack); end
        if (ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", ready); end
        if (pix_rst !== 1'b1) begin failures++; $display("FAIL rst_pix_rst got=%b exp=1", pix_rst); end
        if (busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%b exp=1", busy); end
    endtask

    task automatic test_boot();
        int   n;
        logic prev_pix;
        n = 0;
        prev_pix = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n++;
            if (ready === 1'b1) break;
            prev_pix = pix_rst;
        end
        checks += 6;
        if (n < 214 || n > 216) begin failures++; $display("FAIL boot_ready_latency got=%0d exp=215", n); end
        if (pix_rst !== 1'b0 || prev_pix !== 1'b1) begin failures++; $display("FAIL boot_pix_rst_edge got=%b prev=%b exp=0 prev 1", pix_rst, prev_pix); end
        if (cur_word !== 24'h311017) begin failures++; $display("FAIL boot_cur_word got=%h exp=311017", cur_word); end
        @(posedge clk); #1;
        if (wstr_log.size() != 1) begin failures++; $display("FAIL boot_wstr_count got=%0d exp=1", wstr_log.size()); end
        else if (wstr_log[0] !== 24'h311017) begin failures++; $display("FAIL boot_wstr_data got=%h exp=311017", wstr_log[0]); end
        if (ack_cnt != 0) begin failures++; $display("FAIL boot_no_ack got=%0d exp=0", ack_cnt); end
        if (busy !== 1'b0) begin failures++; $display("FAIL boot_busy got=%b exp=0", busy); end
    endtask

    task automatic test_mode_switch();
        int n;
        n = 0;
        clear_logs();
        pulse_mode(2'd1);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy === 1'b1 && ready === 1'b0) n++;
            else if (n > 0) break;
        end
        checks += 4;
        if (n != 214) begin failures++; $display("FAIL mode_busy_cycles got=%0d exp=214", n); end
        if (cur_word !== 24'h348BF0) begin failures++; $display("FAIL mode_cur_word got=%h exp=348bf0", cur_word); end
        @(posedge clk); #1;
        if (wstr_log.size() != 1) begin failures++; $display("FAIL mode_wstr_count got=%0d exp=1", wstr_log.size()); end
        else if (wstr_log[0] !== 24'h348BF0) begin failures++; $display("FAIL mode_wstr_data got=%h exp=348bf0", wstr_log[0]); end
        if (ack_cnt != 0) begin failures++; $display("FAIL mode_no_ack got=%0d exp=0", ack_cnt); end
    endtask

    task automatic test_skip();
        int ready_low;
        ready_low = 0;
        clear_logs();
        pulse_host(24'h348BF0);
        checks += 2;
        if (host_ack !== 1'b0) begin failures++; $display("FAIL skip_ack_early got=%b exp=0", host_ack); end
        @(negedge clk);
        if (host_ack !== 1'b1) begin failures++; $display("FAIL skip_ack_pulse got=%b exp=1", host_ack); end
        for (int i = 0; i < 10; i++) begin
            if (ready !== 1'b1) ready_low++;
            @(negedge clk);
        end
        checks += 4;
        if (ready_low != 0) begin failures++; $display("FAIL skip_ready_held got=%0d low cycles exp=0", ready_low); end
        @(posedge clk); #1;
        if (wstr_log.size() != 0) begin failures++; $display("FAIL skip_no_wstr got=%0d exp=0", wstr_log.size()); end
        if (ack_cnt != 1) begin failures++; $display("FAIL skip_ack_count got=%0d exp=1", ack_cnt); end
        if (cur_word !== 24'h348BF0) begin failures++; $display("FAIL skip_cur_word got=%h exp=348bf0", cur_word); end
    endtask

    task automatic test_priority();
        clear_logs();
        @(negedge clk);
        host_req  = 1'b1;
        host_data = 24'h123456;
        mode_req  = 1'b1;
        mode_sel  = 2'd0;
        @(negedge clk);
        host_req = 1'b0;
        mode_req = 1'b0;
        repeat (460) @(negedge clk);
        @(posedge clk); #1;
        checks += 4;
        if (wstr_log.size() != 2) begin
            failures++; $display("FAIL prio_wstr_count got=%0d exp=2", wstr_log.size());
        end else begin
            if (wstr_log[0] !== 24'h123456 || wstr_ack_log[0] !== 1'b1) begin
                failures++; $display("FAIL prio_first got=%h ack=%b exp=123456 ack=1", wstr_log[0], wstr_ack_log[0]);
            end
            if (wstr_log[1] !== 24'h311017 || wstr_ack_log[1] !== 1'b0) begin
                failures++; $display("FAIL prio_second got=%h ack=%b exp=311017 ack=0", wstr_log[1], wstr_ack_log[1]);
            end
        end
        if (cur_word !== 24'h311017 || ready !== 1'b1) begin
            failures++; $display("FAIL prio_final got=%h ready=%b exp=311017 ready=1", cur_word, ready);
        end
    endtask

    task automatic test_latest_wins();
        clear_logs();
        pulse_host(24'hABCDEF);
        repeat (10) @(negedge clk);
        pulse_mode(2'd1);
        repeat (3) @(negedge clk);
        pulse_mode(2'd0);
        repeat (460) @(negedge clk);
        @(posedge clk); #1;
        checks += 3;
        if (wstr_log.size() != 2) begin
            failures++; $display("FAIL latest_wstr_count got=%0d exp=2", wstr_log.size());
        end else if (wstr_log[0] !== 24'hABCDEF || wstr_log[1] !== 24'h311017) begin
            failures++; $display("FAIL latest_wstr_data got=%h,%h exp=abcdef,311017", wstr_log[0], wstr_log[1]);
        end
        if (cur_word !== 24'h311017) begin failures++; $display("FAIL latest_cur_word got=%h exp=311017", cur_word); end
        if (ack_cnt != 1) begin failures++; $display("FAIL latest_ack_count got=%0d exp=1", ack_cnt); end
    endtask

    task automatic test_reset_mid_op();
        clear_logs();
        pulse_host(24'h555555);
        repeat (210) @(negedge clk);
        checks += 1;
        if (busy !== 1'b1 || cfg_data !== 24'h555555) begin
            failures++; $display("FAIL midrst_in_settle busy=%b data=%h exp busy=1 data=555555", busy, cfg_data);
        end
        #2 rst = 1'b1;
        #1;
        checks += 5;
        if (cfg_data !== 24'h311017) begin failures++; $display("FAIL midrst_cfg_data got=%h exp=311017", cfg_data); end
        if (cur_word !== 24'h311017) begin failures++; $display("FAIL midrst_cur_word got=%h exp=311017", cur_word); end
        if (ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL midrst_ready_busy got=%b%b exp=01", ready, busy); end
        if (pix_rst !== 1'b1) begin failures++; $display("FAIL midrst_pix_rst got=%b exp=1", pix_rst); end
        if (cfg_wstr !== 1'b0 || host_ack !== 1'b0) begin failures++; $display("FAIL midrst_strobes got=%b%b exp=00", cfg_wstr, host_ack); end
        repeat (3) @(negedge clk);
        clear_logs();
        rst = 1'b0;
        repeat (240) @(negedge clk);
        @(posedge clk); #1;
        checks += 3;
        if (wstr_log.size() != 1) begin
            failures++; $display("FAIL midrst_boot_count got=%0d exp=1", wstr_log.size());
        end else if (wstr_log[0] !== 24'h311017) begin
            failures++; $display("FAIL midrst_boot_data got=%h exp=311017", wstr_log[0]);
        end
        if (ack_cnt != 0) begin failures++; $display("FAIL midrst_no_ack got=%0d exp=0", ack_cnt); end
        if (ready !== 1'b1 || cur_word !== 24'h311017) begin
            failures++; $display("FAIL midrst_final ready=%b word=%h exp 1 311017", ready, cur_word);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        ack_cnt   = 0;
        rst       = 1'b1;
        host_req  = 1'b0;
        host_data = '0;
        mode_req  = 1'b0;
        mode_sel  = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_boot();
        test_mode_switch();
        test_skip();
        test_priority();
        test_latest_wins();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/idt_clock_sequencer.md
Name: idt_clock_sequencer

Overview:
Schedules all reprogramming of the IDT clock synthesizer serial programmer. It arbitrates between two requesters: a host register write carrying a raw 24-bit word, and a video-mode select that indexes four preset words. It drives the serializer's 24-bit data input and write strobe. It times the 24-bit shift-out and the PLL settle period, and holds the pixel domain in reset until the new clock is stable.

Parameters:
MODE0_WORD, 24'h311017, preset word for mode 0 (40 MHz); also the boot word
MODE1_WORD, 24'h348BF0, preset word for mode 1 (25.175 MHz)
MODE2_WORD, 24'h311017, preset word for mode 2
MODE3_WORD, 24'h311017, preset word for mode 3
SHIFT_CYCLES, 205, cycles from cfg_wstr until the serializer has shifted and latched the word
SETTLE_CYCLES, 50000, cycles allowed for PLL relock after the shift completes (benches use 8)

Ports:
clk  in  1  system clock; same clock as the serializer
rst  in  1  asynchronous, active-high reset
host_req  in  1  one-cycle pulse; request to program host_data
host_data  in  24  raw synthesizer word, sampled when host_req=1
host_ack  out  1  one-cycle pulse when the host request is issued or skipped
mode_req  in  1  one-cycle pulse; request to program preset mode_sel
mode_sel  in  2  preset index, sampled when mode_req=1
cfg_data  out  24  word to the serializer din
cfg_wstr  out  1  one-cycle write strobe to the serializer
pix_rst  out  1  holds pixel-clock logic in reset while reprogramming
busy  out  1  1 in any state other than IDLE
ready  out  1  1 when the clock is programmed and settled
cur_word  out  24  last word successfully programmed

Behaviour:
- Reset values, forced asynchronously by rst=1:
  - cfg_data=MODE0_WORD; cur_word=MODE0_WORD
  - cfg_wstr=0; host_ack=0; ready=0
  - pix_rst=1; busy=1
  - pending flags cleared; state=BOOT
- States:
  - BOOT: leaves one cycle after rst deasserts, to LOAD with word=MODE0_WORD (no ack owed).
  - IDLE: ready=1, pix_rst=0, busy=0.
  - LOAD: cfg_data=word; cfg_wstr=1 for exactly one cycle; pix_rst=1; ready=0; counter cleared. Next state SHIFT.
  - SHIFT: count SHIFT_CYCLES cycles after LOAD. Next state SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles. Then cur_word<=word, go to IDLE. ready=1 and pix_rst=0 on the first IDLE cycle.
- Request capture:
  - host_req sets host_pend and latches host_data.
  - mode_req sets mode_pend and latches mode_sel.
  - Capture works in every state. A repeat request of the same type while pending overwrites the latched value (latest wins).
- Arbitration, evaluated only in IDLE:
  - Host has fixed priority over mode.
  - If both are pending, host is served first; mode follows immediately on return to IDLE.
- Skip rule: if the selected word equals cur_word, no reprogramming occurs.
  - The pending flag clears and the state stays IDLE.
  - ready stays 1.
  - host_ack pulses the next cycle if the request was from the host.
- host_ack pulses in the LOAD cycle of a host-originated load.
- A request arriving in the same cycle as the IDLE arbitration is captured. It is served on the next arbitration, not the current one.
- No abort: requests during LOAD/SHIFT/SETTLE never restart the sequence. They remain pending.
- rst mid-sequence returns to BOOT and discards pending requests. A boot reprogram follows.
- Counter widths must hold max(SHIFT_CYCLES, SETTLE_CYCLES) without wrap.

Test Plan:
- Boot: SETTLE_CYCLES=8; release rst.
  - cfg_wstr pulses once with cfg_data=24'h311017.
  - ready rises 1+1+205+8 cycles later (within ±1 of the documented boundary).
  - pix_rst falls the same cycle; cur_word=24'h311017.
- Mode switch: in IDLE, pulse mode_req with mode_sel=1.
  - Exactly one cfg_wstr with 24'h348BF0.
  - busy=1 and ready=0 for 1+205+8 cycles; cur_word=24'h348BF0 after.
- Skip: in IDLE with cur_word=24'h348BF0, host_req with host_data=24'h348BF0.
  - No cfg_wstr; host_ack pulses once; ready stays 1.
- Priority: in IDLE, mode_req (sel=0) and host_req (24'h123456) in the same cycle.
  - First wstr carries 24'h123456 with host_ack.
  - Second wstr carries 24'h311017.
  - Exactly two strobes total.
- Latest wins: during SHIFT, mode_req sel=1, then mode_req sel=0 five cycles later.
  - After SETTLE, a single load of 24'h311017 is issued. Skipped if cur_word already equals it.
- Reset mid-op: assert rst during SETTLE of a host load.
  - Outputs take reset values immediately.
  - After release, a boot load of 24'h311017 occurs; the interrupted host request gets no ack.
